// File: rtl/fifo5x5_scan_ctrl.sv
// Raster sequencer for the depthwise 5x5 line-buffer window FIFO: injects zero padding,
// drives write/clear strobes and offers each legal window to the MAC array via valid/ready.
`timescale 1ns/1ps
module fifo5x5_scan_ctrl #(
    parameter int bitsize     = 14,
    parameter int maxfiforaw  = 28,
    parameter int padding     = 2,
    parameter int window_size = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [5:0]         layer_fifosize,
    input  logic               stride,
    input  logic               pix_valid,
    input  logic [bitsize-1:0] pix_data,
    output logic               pix_ready,
    output logic [bitsize-1:0] fifo_pixel,
    output logic               fifo_wr_en,
    output logic               fifo_clear,
    output logic [5:0]         fifo_size,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [4:0]         win_row,
    output logic [4:0]         win_col,
    output logic               end_of_layer,
    output logic               busy,
    output logic               cfg_err
);

    localparam logic [5:0] PAD      = 6'(padding);
    localparam logic [5:0] LAST_OFF = 6'(2 * padding - 1);
    localparam logic [5:0] WIN_LAST = 6'(window_size - 1);
    localparam logic [4:0] WIN_OFF  = 5'(window_size - 1);
    localparam logic [5:0] N_FULL   = 6'(maxfiforaw);
    localparam logic [5:0] N_HALF   = 6'(maxfiforaw / 2);
    localparam logic [5:0] N_QUART  = 6'(maxfiforaw / 4);

    typedef enum logic [2:0] {
        IDLE,
        CLR0,
        PUSH,
        WAIT_WIN,
        CLR1,
        DONE
    } state_t;

    state_t      state;
    logic [5:0]  row;
    logic [5:0]  col;
    logic [5:0]  n_q;
    logic        stride_q;
    logic        last_q;
    logic [4:0]  win_row_q;
    logic [4:0]  win_col_q;
    logic        cfg_err_q;

    logic [5:0]  p_last;
    logic        border;
    logic        at_win;
    logic        at_last;
    logic        push;
    logic        legal_n;
    logic [4:0]  row_off;
    logic [4:0]  col_off;

    assign p_last  = n_q + LAST_OFF;
    assign border  = (row < PAD) || (row >= n_q + PAD) || (col < PAD) || (col >= n_q + PAD);
    assign at_win  = (row >= WIN_LAST) && (col >= WIN_LAST) && (!stride_q || (!row[0] && !col[0]));
    assign at_last = (row == p_last) && (col == p_last);
    assign push    = (state == PUSH) && (border || pix_valid);
    assign legal_n = (layer_fifosize == N_FULL) || (layer_fifosize == N_HALF) ||
                     (layer_fifosize == N_QUART);
    assign row_off = row[4:0] - WIN_OFF;
    assign col_off = col[4:0] - WIN_OFF;

    // Handshake strobes decode straight from the registered state and counters; only the
    // write strobe and pixel mux look at the upstream valid so an accepted pixel lands this cycle.
    assign pix_ready    = (state == PUSH) && !border;
    assign fifo_clear   = (state == CLR0) || (state == CLR1);
    assign fifo_wr_en   = fifo_clear || push;
    assign fifo_pixel   = (push && !border) ? pix_data : '0;
    assign fifo_size    = n_q;
    assign win_valid    = (state == WAIT_WIN);
    assign win_row      = win_row_q;
    assign win_col      = win_col_q;
    assign end_of_layer = (state == DONE);
    assign busy         = (state != IDLE);
    assign cfg_err      = cfg_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            n_q       <= '0;
            stride_q  <= 1'b0;
            last_q    <= 1'b0;
            win_row_q <= '0;
            win_col_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (legal_n) begin
                            n_q      <= layer_fifosize;
                            stride_q <= stride;
                            state    <= CLR0;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                CLR0: begin
                    row   <= '0;
                    col   <= '0;
                    state <= PUSH;
                end
                PUSH: begin
                    if (push) begin
                        if (col == p_last) begin
                            col <= '0;
                            row <= row + 6'd1;
                        end else begin
                            col <= col + 6'd1;
                        end
                        // Even-sized planes at stride 2 end on an odd corner that completes
                        // no window, so the final push may go straight to the closing clear.
                        if (at_win) begin
                            win_row_q <= row_off;
                            win_col_q <= col_off;
                            last_q    <= at_last;
                            state     <= WAIT_WIN;
                        end else if (at_last) begin
                            state <= CLR1;
                        end
                    end
                end
                WAIT_WIN: begin
                    if (win_ready) begin
                        state <= last_q ? CLR1 : PUSH;
                    end
                end
                CLR1: state <= DONE;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo5x5_scan_ctrl.sv
// Randomized scoreboard bench for fifo5x5_scan_ctrl: a plane-level model predicts every
// pushed pixel and every window; a free-running monitor compares what the DUT presents.
`timescale 1ns/1ps
module tb_fifo5x5_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  layer_fifosize;
    logic        stride;
    logic        pix_valid;
    logic [13:0] pix_data;
    logic        pix_ready;
    logic [13:0] fifo_pixel;
    logic        fifo_wr_en;
    logic        fifo_clear;
    logic [5:0]  fifo_size;
    logic        win_valid;
    logic        win_ready;
    logic [4:0]  win_row;
    logic [4:0]  win_col;
    logic        end_of_layer;
    logic        busy;
    logic        cfg_err;

    fifo5x5_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .layer_fifosize(layer_fifosize), .stride(stride),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .fifo_pixel(fifo_pixel), .fifo_wr_en(fifo_wr_en), .fifo_clear(fifo_clear),
        .fifo_size(fifo_size), .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col), .end_of_layer(end_of_layer),
        .busy(busy), .cfg_err(cfg_err)
    );

    typedef struct {
        int row;
        int col;
        int centre;
        int pushes;
    } exp_t;

    exp_t sb[$];
    int   img[0:783];
    int   pushed[0:1023];

    int checks = 0;
    int errors = 0;
    int cur_n = 7;
    int cur_p = 11;
    int exp_wins = 0;
    int pix_idx = 0;
    int valid_mode = 0;
    int ready_mode = 0;
    int hold_en = 0;
    int hold_cnt = 0;
    int hold33_cycles = 0;
    int push_cnt = 0;
    int layer_pushes = 0;
    int layer_clears = 0;
    int hs_cnt = 0;
    int eol_cnt = 0;
    int cfg_cnt = 0;
    int writes_total = 0;
    int push_after_chk = 0;
    logic drive_en = 1'b0;
    logic tog = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream pixel source and window consumer; both act on the falling edge.
    initial begin
        pix_valid = 1'b0;
        pix_data  = '0;
        win_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (drive_en) begin
                case (valid_mode)
                    0: pix_valid = 1'b1;
                    1: begin tog = ~tog; pix_valid = tog; end
                    default: pix_valid = ($urandom_range(0, 2) != 0);
                endcase
                pix_data = 14'(img[(pix_idx < 784) ? pix_idx : 0]);
                if (hold_en != 0 && win_valid && win_row == 5'd3 && win_col == 5'd3 && hold_cnt < 10) begin
                    win_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    win_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                end
                #1;
                if (pix_valid && pix_ready) pix_idx++;
            end else begin
                pix_valid = 1'b0;
                win_ready = 1'b0;
            end
        end
    end

    // Monitor: samples settled values late in the low phase, i.e. what the next rising edge commits.
    initial begin
        int r, c, e;
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (push_after_chk != 0) begin
                check_output("push_after_release", int'(fifo_wr_en), 1);
                push_after_chk = 0;
            end
            if (fifo_wr_en) begin
                writes_total++;
                if (fifo_clear) begin
                    layer_clears++;
                    check_output("clear_pixel_zero", int'(fifo_pixel), 0);
                    push_cnt = 0;
                end else begin
                    r = push_cnt / cur_p;
                    c = push_cnt % cur_p;
                    if (r < 2 || r >= cur_n + 2 || c < 2 || c >= cur_n + 2) e = 0;
                    else e = img[(r - 2) * cur_n + (c - 2)];
                    check_output("push_pixel", int'(fifo_pixel), e);
                    if (push_cnt < 1024) pushed[push_cnt] = int'(fifo_pixel);
                    push_cnt++;
                    layer_pushes++;
                end
            end
            if (win_valid) begin
                check_output("wr_en_while_window", int'(fifo_wr_en), 0);
                check_output("pix_ready_while_window", int'(pix_ready), 0);
                if (win_row == 5'd3 && win_col == 5'd3) hold33_cycles++;
                if (win_ready) begin
                    hs_cnt++;
                    if (sb.size() == 0) begin
                        check_output("unexpected_window", 1, 0);
                    end else begin
                        x = sb.pop_front();
                        check_output("win_row", int'(win_row), x.row);
                        check_output("win_col", int'(win_col), x.col);
                        check_output("pushes_before_window", push_cnt, x.pushes);
                        check_output("centre_tap",
                                     pushed[((int'(win_row) + 2) * cur_p + int'(win_col) + 2) % 1024],
                                     x.centre);
                    end
                    if (hold_en != 0 && win_row == 5'd3 && win_col == 5'd3) push_after_chk = 1;
                end
            end
            if (end_of_layer) eol_cnt++;
            if (cfg_err) cfg_cnt++;
        end
    end

    // Builds the image and the expected window list, then pulses start.
    task automatic apply_stimulus(input int n, input int s, input int vmode, input int rmode,
                                  input int counting, input int hold);
        int p, step;
        p = n + 4;
        step = (s != 0) ? 2 : 1;
        cur_n = n;
        cur_p = p;
        for (int i = 0; i < n * n; i++) img[i] = (counting != 0) ? i : int'($urandom_range(0, 16383));
        sb.delete();
        exp_wins = 0;
        for (int i = 0; i < n; i += step)
            for (int j = 0; j < n; j += step) begin
                sb.push_back('{i, j, img[i * n + j], (i + 4) * p + (j + 4) + 1});
                exp_wins++;
            end
        layer_pushes = 0;
        layer_clears = 0;
        hs_cnt = 0;
        eol_cnt = 0;
        cfg_cnt = 0;
        hold33_cycles = 0;
        hold_cnt = 0;
        pix_idx = 0;
        tog = 1'b0;
        valid_mode = vmode;
        ready_mode = rmode;
        hold_en = hold;
        drive_en = 1'b1;
        @(negedge clk);
        layer_fifosize = 6'(n);
        stride = s[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_layer(input int n, input int s, input int vmode, input int rmode,
                             input int counting, input int poke, input int hold);
        int done;
        int p;
        p = n + 4;
        apply_stimulus(n, s, vmode, rmode, counting, hold);
        done = 0;
        for (int cyc = 0; cyc < 20000 && done == 0; cyc++) begin
            @(negedge clk);
            if (poke != 0 && cyc == 30) begin
                layer_fifosize = (n == 14) ? 6'd7 : 6'd14;
                stride = ~s[0];
                start = 1'b1;
            end else if (poke != 0 && cyc == 31) begin
                start = 1'b0;
            end
            if (eol_cnt > 0) done = 1;
        end
        if (done == 0) check_output("layer_timeout", 1, 0);
        repeat (3) @(negedge clk);
        drive_en = 1'b0;
        #2;
        check_output("end_of_layer_once", eol_cnt, 1);
        check_output("clear_count", layer_clears, 2);
        check_output("push_count", layer_pushes, p * p);
        check_output("window_count", hs_cnt, exp_wins);
        check_output("windows_left", sb.size(), 0);
        check_output("busy_after_layer", int'(busy), 0);
        check_output("fifo_size_held", int'(fifo_size), n);
        check_output("no_cfg_err", cfg_cnt, 0);
    endtask

    initial begin
        int wt, done;
        rst = 1'b0;
        start = 1'b0;
        layer_fifosize = '0;
        stride = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_fifo_size", int'(fifo_size), 0);
        check_output("reset_win_valid", int'(win_valid), 0);
        check_output("reset_wr_en", int'(fifo_wr_en), 0);
        check_output("reset_pix_ready", int'(pix_ready), 0);
        check_output("reset_win_row", int'(win_row), 0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] N=7 stride 1, counting pixels");
        run_layer(7, 0, 0, 0, 1, 0, 0);
        $display("[TB] N=14 stride 2, random valid/ready");
        run_layer(14, 1, 2, 1, 0, 0, 0);
        $display("[TB] N=7 stride 2");
        run_layer(7, 1, 0, 0, 0, 0, 0);
        $display("[TB] N=7 consumer stall at window (3,3)");
        run_layer(7, 0, 0, 0, 0, 0, 1);
        check_output("stall_cycles_used", hold_cnt, 10);
        check_output("window_3_3_valid_cycles", hold33_cycles, 11);
        $display("[TB] N=7 toggling pixel valid");
        run_layer(7, 0, 1, 0, 1, 0, 0);

        $display("[TB] illegal size and start while busy");
        @(negedge clk);
        layer_fifosize = 6'd20;
        start = 1'b1;
        cfg_cnt = 0;
        wt = writes_total;
        @(negedge clk);
        start = 1'b0;
        #2;
        check_output("cfg_err_pulse", int'(cfg_err), 1);
        check_output("cfg_err_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        #2;
        check_output("cfg_err_count", cfg_cnt, 1);
        check_output("cfg_err_no_writes", writes_total - wt, 0);
        run_layer(14, 0, 2, 1, 0, 1, 0);

        $display("[TB] reset during N=28 layer");
        apply_stimulus(28, 0, 0, 0, 0, 0);
        done = 0;
        for (int cyc = 0; cyc < 20000 && done == 0; cyc++) begin
            @(negedge clk);
            if (hs_cnt >= 20) done = 1;
        end
        if (done == 0) check_output("reset_wait_timeout", 1, 0);
        rst = 1'b0;
        drive_en = 1'b0;
        #1;
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_win_valid", int'(win_valid), 0);
        check_output("abort_wr_en", int'(fifo_wr_en), 0);
        check_output("abort_pix_ready", int'(pix_ready), 0);
        check_output("abort_fifo_size", int'(fifo_size), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        run_layer(28, 0, 0, 0, 0, 0, 0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
